// File: rtl/csr_arb_pkg.sv
// Shared types and constants for the CSR access arbiter.
package csr_arb_pkg;

    localparam int unsigned CSR_DATA_W = 32;
    localparam logic [CSR_DATA_W-1:0] CSR_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/csr_arbiter.sv
// Shares the single-ported CSR block between N_REQ requesters, one
// transaction at a time, with a ready timeout and local RO-write rejection.
module csr_arbiter
    import csr_arb_pkg::*;
#(
    parameter int unsigned           N_REQ      = 2,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           TIMEOUT    = 16,
    parameter logic [ADDR_WIDTH-1:0] RO_ADDR    = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ-1:0]                 req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [N_REQ*CSR_DATA_W-1:0]      req_wdata,
    output logic [N_REQ-1:0]                 req_ack,
    output logic                             req_err,
    output logic [CSR_DATA_W-1:0]            req_rdata,
    output logic                             csr_write_en,
    output logic                             csr_read_en,
    output logic [ADDR_WIDTH-1:0]            csr_addr,
    output logic [CSR_DATA_W-1:0]            csr_wdata,
    input  logic [CSR_DATA_W-1:0]            csr_rdata,
    input  logic                             csr_ready
);

    localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT);

    arb_state_e              state_q,    state_d;
    logic [IDX_W-1:0]        ptr_q,      ptr_d;
    logic [TIMER_W-1:0]      timer_q,    timer_d;
    logic [IDX_W-1:0]        gnt_idx_q,  gnt_idx_d;
    logic                    we_q,       we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [CSR_DATA_W-1:0]   wdata_q,    wdata_d;
    logic                    write_en_q, write_en_d;
    logic                    read_en_q,  read_en_d;
    logic [N_REQ-1:0]        ack_q,      ack_d;
    logic                    err_q,      err_d;
    logic [CSR_DATA_W-1:0]   rdata_q,    rdata_d;

    logic [N_REQ-1:0]        arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_we;
    logic [ADDR_WIDTH-1:0]   arb_addr;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign arb_we   = req_we[arb_idx];
    assign arb_addr = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        gnt_idx_d  = gnt_idx_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
        ack_d      = '0;
        err_d      = 1'b0;
        rdata_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gnt_idx_d = arb_idx;
                    we_d      = arb_we;
                    addr_d    = arb_addr;
                    wdata_d   = req_wdata[arb_idx*CSR_DATA_W +: CSR_DATA_W];
                    if (arb_we && (arb_addr == RO_ADDR)) begin
                        // Rejected locally: the CSR bus never sees it.
                        state_d = RESP;
                        ack_d   = arb_gnt;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        write_en_d = arb_we;
                        read_en_d  = !arb_we;
                    end
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Ready is checked first so it beats a coincident timeout.
                if (csr_ready) begin
                    state_d = RESP;
                    ack_d   = N_REQ'(1) << gnt_idx_q;
                    rdata_d = we_q ? '0 : csr_rdata;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    ack_d   = N_REQ'(1) << gnt_idx_q;
                    err_d   = 1'b1;
                    rdata_d = CSR_TIMEOUT_RDATA;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            RESP: begin
                ptr_d   = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            timer_q    <= '0;
            gnt_idx_q  <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            gnt_idx_q  <= gnt_idx_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_en_q <= write_en_d;
            read_en_q  <= read_en_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign req_ack      = ack_q;
    assign req_err      = err_q;
    assign req_rdata    = rdata_q;
    assign csr_write_en = write_en_q;
    assign csr_read_en  = read_en_q;
    assign csr_addr     = addr_q;
    assign csr_wdata    = wdata_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Scoreboard bench for csr_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares whenever an ack appears.
module tb_csr_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_we    = '0;
    logic [N*AW-1:0]   req_addr  = '0;
    logic [N*32-1:0]   req_wdata = '0;
    logic [N-1:0]      req_ack;
    logic              req_err;
    logic [31:0]       req_rdata;
    logic              csr_write_en, csr_read_en;
    logic [AW-1:0]     csr_addr;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata;
    logic              csr_ready;

    csr_arbiter #(
        .N_REQ      (N),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (16),
        .RO_ADDR    (8'h00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ack      (req_ack),
        .req_err      (req_err),
        .req_rdata    (req_rdata),
        .csr_write_en (csr_write_en),
        .csr_read_en  (csr_read_en),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_ready    (csr_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- CSR block model ----------------
    int         ready_delay = 1;   // 0 = never ready
    int         mdl_cnt     = 0;
    logic       mdl_ready   = 1'b0;
    logic       force_ready = 1'b0;
    logic [7:0] mdl_addr    = '0;

    always @(negedge clk) begin
        if (rst) begin
            mdl_cnt   = 0;
            mdl_ready = 1'b0;
        end else begin
            mdl_ready = 1'b0;
            if (mdl_cnt > 0) begin
                mdl_cnt--;
                if (mdl_cnt == 0) mdl_ready = 1'b1;
            end
            if ((csr_read_en || csr_write_en) && ready_delay > 0) begin
                mdl_cnt  = ready_delay;
                mdl_addr = csr_addr;
            end
        end
    end

    assign csr_ready = mdl_ready | force_ready;
    assign csr_rdata = mdl_ready ? ((mdl_addr == 8'h04) ? 32'h1234_5678 : {24'hC0FFEE, mdl_addr})
                                 : 32'hBAD0_BAD0;

    // ---------------- scoreboard ----------------
    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int         en_count    = 0;
    int         last_en_cyc = 0;
    logic       last_en_we  = 1'b0;
    logic [7:0] last_addr   = '0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (csr_read_en || csr_write_en) begin
                chk("en_exclusive", 32'(csr_read_en & csr_write_en), 32'd0);
                en_count++;
                last_en_cyc = cyc;
                last_en_we  = csr_write_en;
                last_addr   = csr_addr;
                last_wdata  = csr_wdata;
            end
            if (req_ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(req_ack), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_onehot", 32'(req_ack), 32'(1) << mon_e.idx);
                    chk("ack_err",    32'(req_err), 32'(mon_e.err));
                    chk("ack_rdata",  req_rdata,    mon_e.rdata);
                    chk("ack_cycle",  32'(cyc),     32'(mon_e.cyc));
                end
            end
        end
    end

    task automatic push_exp(input int idx, input logic err, input logic [31:0] rd, input int at);
        exp_t e;
        e.idx = idx; e.err = err; e.rdata = rd; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ack"},   32'(req_ack),      32'd0);
        chk({tag, "_err"},   32'(req_err),      32'd0);
        chk({tag, "_rdata"}, req_rdata,         32'd0);
        chk({tag, "_wen"},   32'(csr_write_en), 32'd0);
        chk({tag, "_ren"},   32'(csr_read_en),  32'd0);
        chk({tag, "_addr"},  32'(csr_addr),     32'd0);
        chk({tag, "_wdata"}, csr_wdata,         32'd0);
    endtask

    // One request from an idle arbiter; expected ack at t+lat.
    task automatic do_req(input int idx, input logic we, input logic [7:0] addr,
                          input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                          input int lat, input bit on_bus);
        int t;
        int c0;
        bit got;
        @(negedge clk);
        t  = cyc;
        c0 = en_count;
        req_valid[idx]            = 1'b1;
        req_we[idx]               = we;
        req_addr[idx*AW +: AW]    = addr;
        req_wdata[idx*32 +: 32]   = wd;
        push_exp(idx, e_err, e_rd, t + lat);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ack[idx]) begin
                got = 1'b1;
                break;
            end
        end
        req_valid[idx] = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
        if (on_bus) begin
            chk("en_pulses", 32'(en_count - c0), 32'd1);
            chk("en_cycle",  32'(last_en_cyc),   32'(t + 1));
            chk("en_is_wr",  32'(last_en_we),    32'(we));
            chk("en_addr",   32'(last_addr),     32'(addr));
            if (we) chk("en_wdata", last_wdata, wd);
            chk("addr_hold", 32'(csr_addr), 32'(addr));
        end else begin
            chk("bus_idle", 32'(en_count - c0), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

    initial begin
        int r;
        int t;
        int c0;

        // Both requesters valid through reset.
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {8'h21, 8'h20};
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");

        // Contention: grants alternate 0,1,0,1 one per 4 cycles.
        r   = cyc;
        c0  = en_count;
        rst = 1'b0;
        push_exp(0, 1'b0, 32'hC0FF_EE20, r + 3);
        push_exp(1, 1'b0, 32'hC0FF_EE21, r + 7);
        push_exp(0, 1'b0, 32'hC0FF_EE20, r + 11);
        push_exp(1, 1'b0, 32'hC0FF_EE21, r + 15);
        while (cyc < r + 15) @(negedge clk);
        req_valid = 2'b00;
        chk("contention_en_count", 32'(en_count - c0), 32'd4);

        // Single read, write, RO-write reject.
        do_req(0, 1'b0, 8'h04, 32'h0,         1'b0, 32'h1234_5678, 3, 1'b1);
        do_req(1, 1'b1, 8'h10, 32'hA5A5_5A5A, 1'b0, 32'h0,         3, 1'b1);
        do_req(1, 1'b1, 8'h00, 32'hFFFF_FFFF, 1'b1, 32'h0,         1, 1'b0);

        // Ready while idle must be ignored.
        force_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_ready_ack", 32'(req_ack), 32'd0);
            chk("idle_ready_en",  32'(csr_read_en | csr_write_en), 32'd0);
        end
        force_ready = 1'b0;

        // Timeout, then a normal transaction.
        ready_delay = 0;
        do_req(0, 1'b0, 8'h30, 32'h0, 1'b1, 32'hDEAD_BEEF, 18, 1'b1);
        ready_delay = 1;
        do_req(1, 1'b0, 8'h31, 32'h0, 1'b0, 32'hC0FF_EE31, 3, 1'b1);

        // Ready on the last timeout cycle wins; one cycle later it times out.
        ready_delay = 16;
        do_req(0, 1'b0, 8'h04, 32'h0, 1'b0, 32'h1234_5678, 18, 1'b1);
        ready_delay = 17;
        do_req(1, 1'b0, 8'h05, 32'h0, 1'b1, 32'hDEAD_BEEF, 18, 1'b1);

        // Leave ptr at 1, then reset during WAIT.
        ready_delay = 1;
        do_req(0, 1'b0, 8'h06, 32'h0, 1'b0, 32'hC0FF_EE06, 3, 1'b1);
        ready_delay = 0;
        @(negedge clk);
        t = cyc;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[AW +: AW] = 8'h07;
        while (cyc < t + 4) @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;

        // ptr must be back at 0: requester 0 wins first.
        ready_delay = 1;
        @(negedge clk);
        t = cyc;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {8'h41, 8'h40};
        push_exp(0, 1'b0, 32'hC0FF_EE40, t + 3);
        push_exp(1, 1'b0, 32'hC0FF_EE41, t + 7);
        while (cyc < t + 3) @(negedge clk);
        req_valid[0] = 1'b0;
        while (cyc < t + 7) @(negedge clk);
        req_valid[1] = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
